// File: rtl/lutram_sfifo_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// lutram_sfifo_ctrl_pkg
// Shared definitions for the LUT-RAM first-word-fall-through FIFO:
//   count_width()  - width of the occupancy counter (ADDR_WIDTH+1, so DEPTH fits)
//   params_legal() - range check on ADDR_WIDTH / AFULL_TH / AEMPTY_TH, used at
//                    elaboration to reject bad instantiations
//   fifo_flags_t   - registered status flags of the FIFO
//   FLAGS_RST      - flag values after reset / clear
// ---------------------------------------------------------------------------
package lutram_sfifo_ctrl_pkg;

  function automatic int count_width(input int addr_width);
    return addr_width + 1;
  endfunction

  function automatic bit params_legal(input int addr_width, input int afull_th,
                                      input int aempty_th);
    int depth;
    if (addr_width < 1 || addr_width > 10) return 1'b0;
    depth = 1 << addr_width;
    if (afull_th < 1 || afull_th > depth) return 1'b0;
    if (aempty_th < 0 || aempty_th > depth - 1) return 1'b0;
    return 1'b1;
  endfunction

  typedef struct packed {
    logic rvld;
    logic full;
    logic afull;
    logic aempty;
  } fifo_flags_t;

  localparam fifo_flags_t FLAGS_RST = '{rvld: 1'b0, full: 1'b0, afull: 1'b0, aempty: 1'b1};

endpackage

// File: rtl/lutram_sfifo_ctrl_if.sv
// ---------------------------------------------------------------------------
// lutram_sfifo_ctrl_if
// Write/read handshake bundle of the FIFO.
//   master modport (user side): drives clr, wen, wdata, ren; observes status.
//   slave  modport (FIFO side): receives requests; drives full, afull, rdata,
//                               rvld, aempty, count, ovf_err, udf_err.
// ---------------------------------------------------------------------------
interface lutram_sfifo_ctrl_if
  import lutram_sfifo_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 5
) ();
  localparam int CW = count_width(ADDR_WIDTH);

  logic                  clr;
  logic                  wen;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  full;
  logic                  afull;
  logic                  ren;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  rvld;
  logic                  aempty;
  logic [CW-1:0]         count;
  logic                  ovf_err;
  logic                  udf_err;

  modport master (
    output clr, wen, wdata, ren,
    input  full, afull, rdata, rvld, aempty, count, ovf_err, udf_err
  );

  modport slave (
    input  clr, wen, wdata, ren,
    output full, afull, rdata, rvld, aempty, count, ovf_err, udf_err
  );
endinterface

// File: rtl/lutram_sfifo_ctrl_lutram.sv
// ---------------------------------------------------------------------------
// xilinx_lutram
// Distributed-RAM wrapper: synchronous write on clk_wr, combinational read.
//   clk_wr, clk_rd  write / read clocks (read path is asynchronous, so clk_rd
//                   only exists for port compatibility with the primitive)
//   reset           blocks writes while high; contents are never cleared
//   wren, wraddress, data   write port
//   rden, rdaddress, q      read port (q forced to 0 when rden is low)
// ---------------------------------------------------------------------------
module xilinx_lutram #(
  parameter int RAM_WIDTH = 8,
  parameter int RAM_DEEP  = 5
) (
  input  logic                 clk_wr,
  input  logic                 clk_rd,
  input  logic                 reset,
  input  logic                 wren,
  input  logic [RAM_DEEP-1:0]  wraddress,
  input  logic [RAM_WIDTH-1:0] data,
  input  logic                 rden,
  input  logic [RAM_DEEP-1:0]  rdaddress,
  output logic [RAM_WIDTH-1:0] q
);
  localparam int WORDS = 2 ** RAM_DEEP;

  logic [RAM_WIDTH-1:0] mem [WORDS];

  // The read side is combinational, so the read clock has no load.
  logic unused_clk_rd;
  assign unused_clk_rd = clk_rd;

  always_ff @(posedge clk_wr) begin
    if (wren && !reset) begin
      mem[wraddress] <= data;
    end
  end

  assign q = rden ? mem[rdaddress] : '0;
endmodule

// File: rtl/lutram_sfifo_ctrl.sv
// ---------------------------------------------------------------------------
// lutram_sfifo_ctrl
// Single-clock FWFT FIFO on top of xilinx_lutram. Holds the pointers, the
// occupancy counters, the status flags and a one-word output register that
// presents the head word (rdata/rvld).
//   clk    single clock (also RAM write/read clock)
//   reset  synchronous, active-high
//   bus    lutram_sfifo_ctrl_if.slave: clr, wen/wdata, ren in;
//          full, afull, rdata, rvld, aempty, count, ovf_err, udf_err out
// Total capacity is DEPTH words counting the output register.
// ---------------------------------------------------------------------------
module lutram_sfifo_ctrl
  import lutram_sfifo_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 5,
  parameter int AFULL_TH   = 2 ** ADDR_WIDTH - 2,
  parameter int AEMPTY_TH  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  lutram_sfifo_ctrl_if.slave    bus
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int CW    = count_width(ADDR_WIDTH);

  localparam logic [CW-1:0]         DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0]         AFULL_C  = CW'(AFULL_TH);
  localparam logic [CW-1:0]         AEMPTY_C = CW'(AEMPTY_TH);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = ADDR_WIDTH'(1);

  if (!params_legal(ADDR_WIDTH, AFULL_TH, AEMPTY_TH)) begin : g_bad_params
    $error("lutram_sfifo_ctrl: ADDR_WIDTH/AFULL_TH/AEMPTY_TH out of range");
  end

  logic [ADDR_WIDTH-1:0] wr_ptr_reg;
  logic [ADDR_WIDTH-1:0] rd_ptr_reg;
  logic [CW-1:0]         ram_cnt_reg;
  logic [CW-1:0]         count_reg;
  logic [DATA_WIDTH-1:0] rdata_reg;
  fifo_flags_t           flags_reg;
  logic                  ovf_reg;
  logic                  udf_reg;

  logic                  flush;
  logic                  wacc;
  logic                  pop;
  logic                  load;
  logic [CW-1:0]         ram_cnt_next;
  logic [CW-1:0]         count_next;
  logic [DATA_WIDTH-1:0] ram_q;

  // A flush cycle must not write the RAM either, otherwise the write pointer
  // would be reset while a word lands at the old address.
  assign flush = reset | bus.clr;
  assign wacc  = bus.wen & ~flags_reg.full & ~flush;
  assign pop   = bus.ren & flags_reg.rvld;
  // Refill the output register when it is empty or being emptied this cycle.
  assign load  = (ram_cnt_reg != '0) & (~flags_reg.rvld | pop);

  assign ram_cnt_next = ram_cnt_reg + CW'(wacc) - CW'(load);
  assign count_next   = count_reg + CW'(wacc) - CW'(pop);

  xilinx_lutram #(
    .RAM_WIDTH (DATA_WIDTH),
    .RAM_DEEP  (ADDR_WIDTH)
  ) u_ram (
    .clk_wr    (clk),
    .clk_rd    (clk),
    .reset     (1'b0),
    .wren      (wacc),
    .wraddress (wr_ptr_reg),
    .data      (bus.wdata),
    .rden      (1'b1),
    .rdaddress (rd_ptr_reg),
    .q         (ram_q)
  );

  always_ff @(posedge clk) begin
    if (reset || bus.clr) begin
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      ram_cnt_reg <= '0;
      count_reg   <= '0;
      rdata_reg   <= '0;
      flags_reg   <= FLAGS_RST;
      ovf_reg     <= 1'b0;
      udf_reg     <= 1'b0;
    end else begin
      if (wacc) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      end
      if (load) begin
        rdata_reg      <= ram_q;
        rd_ptr_reg     <= rd_ptr_reg + PTR_ONE;
        flags_reg.rvld <= 1'b1;
      end else if (pop) begin
        flags_reg.rvld <= 1'b0;
      end
      ram_cnt_reg      <= ram_cnt_next;
      count_reg        <= count_next;
      flags_reg.full   <= (count_next == DEPTH_C);
      flags_reg.afull  <= (count_next >= AFULL_C);
      flags_reg.aempty <= (count_next <= AEMPTY_C);
      // full is the pre-edge value, so wen together with a pop on a full
      // FIFO is still an overflow.
      ovf_reg          <= bus.wen & flags_reg.full;
      udf_reg          <= bus.ren & ~flags_reg.rvld;
    end
  end

  assign bus.full    = flags_reg.full;
  assign bus.afull   = flags_reg.afull;
  assign bus.aempty  = flags_reg.aempty;
  assign bus.rvld    = flags_reg.rvld;
  assign bus.rdata   = rdata_reg;
  assign bus.count   = count_reg;
  assign bus.ovf_err = ovf_reg;
  assign bus.udf_err = udf_reg;
endmodule
